// File: rtl/float_pkg.sv
// Shared definitions for the float-to-unsigned converter.
//   - IEEE-754 single-precision field positions and constants
//   - FSM state encoding used by float_to_ui
//   - operand class enum produced by f2u_classify
package float_pkg;

   localparam int          FLOAT_BIAS  = 127;
   localparam logic [7:0]  EXP_SPECIAL = 8'hFF;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int FRAC_MSB = 22;
   localparam int MANT_W   = 24;   // hidden one + 23 fraction bits

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } f2u_state_t;

   typedef enum logic [2:0] {
      CLS_ZERO,     // +/-0
      CLS_DENORM,   // exp==0, frac!=0
      CLS_FRACT,    // 0 < |value| < 1
      CLS_NORMAL,   // positive, 1 <= value < 2^32
      CLS_OVF,      // +Inf or positive value >= 2^32
      CLS_NEG,      // -Inf or value <= -1
      CLS_NAN
   } f2u_class_t;

endpackage

// File: rtl/f2u_classify.sv
// Combinational operand classifier for float_to_ui.
// Ports:
//   data          in  32  float operand {sign, exp[7:0], frac[22:0]}
//   cls           out     operand class
//   mant          out 24  {1, frac}
//   shamt         out 5   |k|, where k = exp - 127 - 23 (valid for CLS_NORMAL)
//   shift_left    out 1   1 when k > 0
//   early_data    out 32  result when no alignment is needed
//   early_invalid out 1   invalid flag for the early result
//   early_inexact out 1   inexact flag for the early result
module f2u_classify
   import float_pkg::*;
#(
   parameter logic [31:0] OVF_RESULT = 32'hFFFF_FFFF,
   parameter logic [31:0] NEG_RESULT = 32'h0000_0000
) (
   input  logic [31:0]        data,
   output f2u_class_t         cls,
   output logic [MANT_W-1:0]  mant,
   output logic [4:0]         shamt,
   output logic               shift_left,
   output logic [31:0]        early_data,
   output logic               early_invalid,
   output logic               early_inexact
);

   logic              sign;
   logic [7:0]        exp;
   logic [FRAC_MSB:0] frac;
   logic signed [9:0] e;   // unbiased exponent
   logic signed [9:0] k;   // alignment distance relative to the integer LSB

   assign sign = data[SIGN_BIT];
   assign exp  = data[EXP_MSB:EXP_LSB];
   assign frac = data[FRAC_MSB:0];
   assign mant = {1'b1, frac};

   assign e = $signed({2'b00, exp}) - $signed(10'(FLOAT_BIAS));
   assign k = e - 10'sd23;

   assign shift_left = (k > 10'sd0);
   // Only meaningful for CLS_NORMAL, where k spans -23..8.
   assign shamt = 5'((k < 10'sd0) ? -k : k);

   always_comb begin
      cls = CLS_NORMAL;
      if (exp == EXP_SPECIAL && frac != '0)
         cls = CLS_NAN;
      else if (!sign && (exp == EXP_SPECIAL || e >= 10'sd32))
         cls = CLS_OVF;
      else if (sign && (exp == EXP_SPECIAL || e >= 10'sd0))
         cls = CLS_NEG;
      else if (exp == 8'd0 && frac == '0)
         cls = CLS_ZERO;
      else if (exp == 8'd0)
         cls = CLS_DENORM;
      else if (e < 10'sd0)
         cls = CLS_FRACT;
   end

   always_comb begin
      early_data    = 32'd0;
      early_invalid = 1'b0;
      early_inexact = 1'b0;
      case (cls)
         CLS_NAN, CLS_OVF: begin
            early_data    = OVF_RESULT;
            early_invalid = 1'b1;
         end
         CLS_NEG: begin
            early_data    = NEG_RESULT;
            early_invalid = 1'b1;
         end
         CLS_DENORM, CLS_FRACT: begin
            // Magnitude below one truncates to zero, sign irrelevant.
            early_inexact = 1'b1;
         end
         CLS_NORMAL: begin
            // Used directly when k==0 (exponent 23).
            early_data = {8'd0, mant};
         end
         default: begin
            early_data = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/float_to_ui.sv
// Multi-cycle IEEE-754 single -> 32-bit unsigned converter, round toward zero.
// The mantissa is aligned by an iterative shifter moving SHIFT_STEP bits per cycle.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     operand valid
//   in_ready     converter idle; operand accepted on in_valid && in_ready
//   in_data      float operand
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   out_data     unsigned integer result
//   out_invalid  NaN, Inf, out of range or value <= -1
//   out_inexact  nonzero fraction bits discarded (only when not invalid)
module float_to_ui
   import float_pkg::*;
#(
   parameter int          SHIFT_STEP = 1,
   parameter logic [31:0] OVF_RESULT = 32'hFFFF_FFFF,
   parameter logic [31:0] NEG_RESULT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_invalid,
   output logic        out_inexact
);

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   f2u_state_t        state;
   logic [31:0]       acc;
   logic [4:0]        cnt;
   logic              dir_left;
   logic              sticky;

   f2u_class_t        cls;
   logic [MANT_W-1:0] mant;
   logic [4:0]        shamt;
   logic              shift_left;
   logic [31:0]       early_data;
   logic              early_invalid;
   logic              early_inexact;

   logic [4:0]        step;
   logic [31:0]       acc_next;
   logic              sticky_next;
   logic              needs_shift;

   f2u_classify #(
      .OVF_RESULT (OVF_RESULT),
      .NEG_RESULT (NEG_RESULT)
   ) u_classify (
      .data          (in_data),
      .cls           (cls),
      .mant          (mant),
      .shamt         (shamt),
      .shift_left    (shift_left),
      .early_data    (early_data),
      .early_invalid (early_invalid),
      .early_inexact (early_inexact)
   );

   // Bits that fall off the bottom of a right shift by n.
   function automatic logic [31:0] low_mask(input logic [4:0] n);
      low_mask = (32'd1 << n) - 32'd1;
   endfunction

   assign in_ready    = (state == ST_IDLE);
   assign out_valid   = (state == ST_DONE);
   assign needs_shift = (cls == CLS_NORMAL) && (shamt != 5'd0);

   always_comb begin
      step        = (cnt < STEP) ? cnt : STEP;
      acc_next    = dir_left ? (acc << step) : (acc >> step);
      sticky_next = sticky;
      if (!dir_left)
         sticky_next = sticky | (|(acc & low_mask(step)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         acc         <= 32'd0;
         cnt         <= 5'd0;
         dir_left    <= 1'b0;
         sticky      <= 1'b0;
         out_data    <= 32'd0;
         out_invalid <= 1'b0;
         out_inexact <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (needs_shift) begin
                     acc      <= {8'd0, mant};
                     cnt      <= shamt;
                     dir_left <= shift_left;
                     sticky   <= 1'b0;
                     state    <= ST_SHIFT;
                  end else begin
                     out_data    <= early_data;
                     out_invalid <= early_invalid;
                     out_inexact <= early_inexact;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               acc    <= acc_next;
               cnt    <= cnt - step;
               sticky <= sticky_next;
               // Last partial step lands exactly on zero.
               if (cnt == step) begin
                  out_data    <= acc_next;
                  out_invalid <= 1'b0;
                  out_inexact <= sticky_next;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready)
                  state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_ui.sv
module tb_float_to_ui;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_invalid;
   logic        out_inexact;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] data;
      logic        inv;
      logic        inx;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t q[$];
   bit   seen = 1'b0;

   float_to_ui #(
      .SHIFT_STEP (1),
      .OVF_RESULT (32'hFFFF_FFFF),
      .NEG_RESULT (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_invalid (out_invalid),
      .out_inexact (out_inexact)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: compares every cycle the DUT presents a result; pops on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %h with no pending operand", out_data);
         end else begin
            if (!seen) begin
               check("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
               seen = 1'b1;
            end
            check("out_data", out_data, q[0].data);
            check("out_invalid", {31'd0, out_invalid}, {31'd0, q[0].inv});
            check("out_inexact", {31'd0, out_inexact}, {31'd0, q[0].inx});
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input logic [31:0] d, input logic [31:0] rdata, input logic inv,
                        input logic inx, input int lat, input bit track);
      int tries = 0;
      exp_t e;
      @(negedge clk);
      while (!in_ready && tries < 200) begin
         @(negedge clk);
         tries++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
      end else begin
         in_valid = 1'b1;
         in_data  = d;
         if (track) begin
            e.data = rdata; e.inv = inv; e.inx = inx; e.lat = lat; e.acc_cyc = cyc;
            q.push_back(e);
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int tries = 0;
      while (q.size() != 0 && tries < 300) begin
         @(negedge clk);
         tries++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      end
   endtask

   // Directed vectors: operand, result, invalid, inexact, latency (SHIFT_STEP=1)
   typedef struct {
      logic [31:0] d;
      logic [31:0] r;
      logic        inv;
      logic        inx;
      int          lat;
   } vec_t;

   vec_t vecs[] = '{
      '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 24},  // 1.0
      '{32'h4070_0000, 32'h0000_0003, 1'b0, 1'b1, 23},  // 3.75
      '{32'h4F00_0000, 32'h8000_0000, 1'b0, 1'b0,  9},  // 2^31
      '{32'h4F7F_FFFF, 32'hFFFF_FF00, 1'b0, 1'b0,  9},  // largest below 2^32
      '{32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0,  1},  // 2^32
      '{32'h7FC0_0000, 32'hFFFF_FFFF, 1'b1, 1'b0,  1},  // NaN
      '{32'h7F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0,  1},  // +Inf
      '{32'hFF80_0000, 32'h0000_0000, 1'b1, 1'b0,  1},  // -Inf
      '{32'hBFC0_0000, 32'h0000_0000, 1'b1, 1'b0,  1},  // -1.5
      '{32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b1,  1},  // -0.5
      '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0,  1},  // -0
      '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1,  1},  // denormal
      '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1,  1},  // 0.5
      '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 24},  // 1.5
      '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0,  1},  // 2^23, no shift
      '{32'h4B80_0001, 32'h0100_0002, 1'b0, 1'b0,  2},  // 2^24+2, one left shift
      '{32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 21}   // 10.0
   };

   initial begin
      #1 rst = 1'b1;
      #11;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      out_ready = 1'b1;
      foreach (vecs[i])
         issue(vecs[i].d, vecs[i].r, vecs[i].inv, vecs[i].inx, vecs[i].lat, 1'b1);
      drain();

      // Consumer stalls for 5 cycles; a competing operand must be ignored.
      out_ready = 1'b0;
      issue(32'h4070_0000, 32'h0000_0003, 1'b0, 1'b1, 23, 1'b1);
      begin
         int tries = 0;
         while (!out_valid && tries < 100) begin
            @(negedge clk);
            tries++;
         end
      end
      in_valid = 1'b1;
      in_data  = 32'h3F80_0000;
      repeat (5) @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (3) @(negedge clk);

      // Reset in the middle of a 1.0 conversion: no result may appear.
      issue(32'h3F80_0000, 32'd0, 1'b0, 1'b0, 0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 21, 1'b1);
      drain();
      repeat (30) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
